// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Blocking, direct-mapped, write-through data cache sitting between the MEM
// stage and the backing data memory. One 32-bit word per line.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   MEM[1:0]          bit0 = load, bit1 = store (11 behaves as a store)
//   Addr, Wdata       byte address and store data from the EX/MEM latch
//   Rdata             load data back to the MEM/WB latch
//   BUSY              combinational stall request to the pipeline controller
//   mem_req/mem_we    registered backing-memory request and direction
//   mem_addr/mem_wdata word-aligned request address and write data
//   mem_rdata/mem_ack read data and one-cycle completion pulse from memory
module dcache_ctrl #(
    parameter int IDX_BITS = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        MEM,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Wdata,
    output logic [31:0]       Rdata,
    output logic              BUSY,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int LINES = 2 ** IDX_BITS;
    localparam int TAG_W = ADDR_W - 2 - IDX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [TAG_W-1:0]      tag_d  [LINES];
    logic [31:0]           data_q [LINES];
    logic [31:0]           data_d [LINES];
    logic [31:0]           resp_q, resp_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [IDX_BITS-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic                  hit, is_store, is_load;
    logic [1:0]            unused_addr_bits;

    // Byte offset is ignored: all accesses are word-aligned.
    assign unused_addr_bits = Addr[1:0];

    assign req_idx  = Addr[IDX_BITS+1:2];
    assign req_tag  = Addr[ADDR_W-1:IDX_BITS+2];
    // The fill writes the line addressed by the captured request, so the
    // inputs need not be re-sampled once the FSM has left IDLE.
    assign fill_idx = mem_addr_q[IDX_BITS+1:2];
    assign fill_tag = mem_addr_q[ADDR_W-1:IDX_BITS+2];

    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign is_store = MEM[1];
    assign is_load  = (MEM == 2'b01);

    // Next-state and line-update logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        resp_d      = resp_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {Addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = Wdata;
                    // Store hits update the cached copy; misses do not allocate.
                    if (hit) begin
                        data_d[req_idx] = Wdata;
                    end
                end else if (is_load && !hit) begin
                    state_d    = FILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {Addr[ADDR_W-1:2], 2'b00};
                end
            end
            FILL: begin
                if (mem_ack) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = fill_tag;
                    data_d[fill_idx]  = mem_rdata;
                    resp_d            = mem_rdata;
                    mem_req_d         = 1'b0;
                    state_d           = DONE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall and load-data outputs; a load hit returns data with no delay.
    always_comb begin
        BUSY  = 1'b0;
        Rdata = resp_q;
        if (state_q == IDLE) begin
            Rdata = data_q[req_idx];
        end
        if (!rst) begin
            case (state_q)
                IDLE:        BUSY = is_store || (is_load && !hit);
                FILL, WRITE: BUSY = 1'b1;
                default:     BUSY = 1'b0;
            endcase
        end
    end

    // State registers; tag/data arrays are not reset since valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            resp_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            resp_q      <= resp_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// Directed self-checking bench for dcache_ctrl. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  MEM;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        BUSY;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(.IDX_BITS(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM       (MEM),
        .Addr      (Addr),
        .Wdata     (Wdata),
        .Rdata     (Rdata),
        .BUSY      (BUSY),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a miss or store, play the memory side with an ack arriving
    // ackDelay cycles after mem_req rises, and check the DONE cycle.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a,
                                 input logic [31:0] wd, input int ackDelay,
                                 input logic [31:0] rd, input logic expWe);
        int  busyCnt;
        int  reqCnt;
        bit  done;
        logic [31:0] expAddr;
        busyCnt = 0;
        reqCnt  = 0;
        done    = 1'b0;
        expAddr = {a[31:2], 2'b00};
        @(posedge clk); #1;
        MEM   = m;
        Addr  = a;
        Wdata = wd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (BUSY) begin
                busyCnt++;
                if (mem_req) begin
                    reqCnt++;
                    if (reqCnt == 1) begin
                        checkOutput("req_we", {31'b0, mem_we}, {31'b0, expWe});
                        checkOutput("req_addr", mem_addr, expAddr);
                        if (expWe) checkOutput("req_wdata", mem_wdata, wd);
                    end
                    if (reqCnt == ackDelay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                    end
                end
            end else begin
                done = 1'b1;
                checkOutput("done_req", {31'b0, mem_req}, 32'd0);
                if (m == 2'b01) checkOutput("done_rdata", Rdata, rd);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        MEM = 2'b00;
        if (!done) checkOutput("timeout", 32'd1, 32'd0);
        checkOutput("busy_cycles", busyCnt, 1 + ackDelay);
    endtask

    // A load that must hit: zero stall, cached data, no memory request.
    task automatic doHit(input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        MEM  = 2'b01;
        Addr = a;
        @(negedge clk);
        checkOutput("hit_busy", {31'b0, BUSY}, 32'd0);
        checkOutput("hit_rdata", Rdata, exp);
        @(posedge clk); #1;
        MEM = 2'b00;
        @(negedge clk);
        checkOutput("hit_noreq", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        MEM       = 2'b00;
        Addr      = 32'h0;
        Wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, BUSY}, 32'd0);
        checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);

        // Cold load miss, then the same load hits.
        applyStimulus(2'b01, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        doHit(32'h0000_0040, 32'hDEAD_BEEF);

        // Store hit updates the line as well as writing through.
        applyStimulus(2'b10, 32'h0000_0040, 32'h1234_5678, 2, 32'h0, 1'b1);
        doHit(32'h0000_0040, 32'h1234_5678);

        // Store miss does not allocate; the following load must fill.
        applyStimulus(2'b10, 32'h0000_0080, 32'h0000_0001, 1, 32'h0, 1'b1);
        applyStimulus(2'b01, 32'h0000_0080, 32'h0, 2, 32'hCAFE_0080, 1'b0);

        // Conflicting tags at index 0 evict each other.
        applyStimulus(2'b01, 32'h0000_0440, 32'h0, 1, 32'h0440_0440, 1'b0);
        applyStimulus(2'b01, 32'h0000_0040, 32'h0, 2, 32'h4040_4040, 1'b0);
        doHit(32'h0000_0040, 32'h4040_4040);

        // Reset while a fill is outstanding.
        @(posedge clk); #1;
        MEM  = 2'b01;
        Addr = 32'h0000_0050;
        @(posedge clk); #1;
        checkOutput("midfill_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        MEM = 2'b00;
        @(negedge clk);
        checkOutput("midfill_rst_busy", {31'b0, BUSY}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("postrst_busy", {31'b0, BUSY}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("lateack_req", {31'b0, mem_req}, 32'd0);
        checkOutput("lateack_busy", {31'b0, BUSY}, 32'd0);

        // Valid bits were cleared, so the previously cached line misses.
        applyStimulus(2'b01, 32'h0000_0040, 32'h0, 1, 32'hAAAA_5555, 1'b0);

        // MEM=11 is a store: write-through, no allocation.
        applyStimulus(2'b11, 32'h0000_0100, 32'h0000_FEED, 2, 32'h0, 1'b1);
        applyStimulus(2'b01, 32'h0000_0100, 32'h0, 1, 32'h0100_0100, 1'b0);
        doHit(32'h0000_0100, 32'h0100_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
